// File: rtl/opl2_cmd_parser.sv
// UART byte-stream decoder for the OPL2 core: buffers received bytes in a
// show-ahead FIFO and turns them into register writes, sample waits and chip resets.
module opl2_cmd_parser #(
    parameter int FIFO_DEPTH = 16,
    parameter int RST_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_eop,
    input  logic       sample_tick,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic       chip_rst,
    output logic       busy,
    output logic       overflow,
    output logic       err_opcode
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // One timer serves both the 16-bit wait count and the reset hold count.
    localparam int TMR_W = ($clog2(RST_CYCLES + 1) > 16) ? $clog2(RST_CYCLES + 1) : 16;

    typedef enum logic [2:0] {IDLE, ARG1, ARG2, WRITE, WAIT, RESET} stateType;

    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtrReg, rdPtrReg;
    logic [CNT_W-1:0] countReg;
    logic             overflowReg;
    logic             fifoFull, fifoEmpty, push, pop;
    logic [7:0]       head;

    stateType         stateReg, stateNext;
    logic [7:0]       opcodeReg, opcodeNext;
    logic [7:0]       arg0Reg, arg0Next;
    logic [7:0]       wrAddrReg, wrAddrNext;
    logic [7:0]       wrDataReg, wrDataNext;
    logic [TMR_W-1:0] timerReg, timerNext;
    logic             errReg, errNext;

    // Full is judged on the start-of-cycle count, so a same-cycle pop never rescues a push.
    assign fifoFull  = (countReg == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty = (countReg == '0);
    assign push      = rx_valid && !fifoFull;
    assign head      = fifoMem[rdPtrReg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtrReg] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtrReg    <= '0;
            rdPtrReg    <= '0;
            countReg    <= '0;
            overflowReg <= 1'b0;
        end else begin
            if (push) wrPtrReg <= wrPtrReg + PTR_W'(1);
            if (pop)  rdPtrReg <= rdPtrReg + PTR_W'(1);
            case ({push, pop})
                2'b10:   countReg <= countReg + CNT_W'(1);
                2'b01:   countReg <= countReg - CNT_W'(1);
                default: countReg <= countReg;
            endcase
            if (rx_valid && fifoFull) overflowReg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg  <= IDLE;
            opcodeReg <= '0;
            arg0Reg   <= '0;
            wrAddrReg <= '0;
            wrDataReg <= '0;
            timerReg  <= '0;
            errReg    <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            opcodeReg <= opcodeNext;
            arg0Reg   <= arg0Next;
            wrAddrReg <= wrAddrNext;
            wrDataReg <= wrDataNext;
            timerReg  <= timerNext;
            errReg    <= errNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        opcodeNext = opcodeReg;
        arg0Next   = arg0Reg;
        wrAddrNext = wrAddrReg;
        wrDataNext = wrDataReg;
        timerNext  = timerReg;
        errNext    = 1'b0;
        pop        = 1'b0;
        case (stateReg)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop = 1'b1;
                    case (head)
                        8'hA0, 8'hA1: begin
                            opcodeNext = head;
                            stateNext  = ARG1;
                        end
                        8'hA2: begin
                            timerNext = TMR_W'(RST_CYCLES);
                            stateNext = RESET;
                        end
                        default: errNext = 1'b1;
                    endcase
                end
            end
            ARG1: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    arg0Next  = head;
                    stateNext = ARG2;
                end else if (rx_eop) begin
                    errNext   = 1'b1;
                    stateNext = IDLE;
                end
            end
            ARG2: begin
                if (!fifoEmpty) begin
                    pop = 1'b1;
                    if (opcodeReg == 8'hA0) begin
                        wrAddrNext = arg0Reg;
                        wrDataNext = head;
                        stateNext  = WRITE;
                    end else if ({head, arg0Reg} == 16'h0000) begin
                        stateNext = IDLE;
                    end else begin
                        timerNext = TMR_W'({head, arg0Reg});
                        stateNext = WAIT;
                    end
                end else if (rx_eop) begin
                    errNext   = 1'b1;
                    stateNext = IDLE;
                end
            end
            WRITE: begin
                if (wr_ready) stateNext = IDLE;
            end
            WAIT: begin
                // The tick seen in the exit cycle is the Nth one consumed.
                if (sample_tick) begin
                    if (timerReg == TMR_W'(1)) stateNext = IDLE;
                    else                       timerNext = timerReg - TMR_W'(1);
                end
            end
            RESET: begin
                if (timerReg == TMR_W'(1)) stateNext = IDLE;
                else                       timerNext = timerReg - TMR_W'(1);
            end
            default: stateNext = IDLE;
        endcase
    end

    assign wr_addr    = wrAddrReg;
    assign wr_data    = wrDataReg;
    assign wr_valid   = (stateReg == WRITE);
    assign chip_rst   = (stateReg == RESET);
    assign busy       = (stateReg != IDLE) || !fifoEmpty;
    assign overflow   = overflowReg;
    assign err_opcode = errReg;
endmodule

// File: tb/tb_opl2_cmd_parser.sv
// Directed bench for opl2_cmd_parser: byte-level command sequences with
// hand-computed cycle timing and a negedge monitor logging each register write.
module tb_opl2_cmd_parser;
    logic       clk = 1'b0;
    logic       rst_n, rx_valid, rx_eop, sample_tick, wr_ready;
    logic [7:0] rx_data;
    logic [7:0] wr_addr, wr_data;
    logic       wr_valid, chip_rst, busy, overflow, err_opcode;

    int testsRun = 0;
    int testsFailed = 0;
    logic [7:0] wrAddrQ [$];
    logic [7:0] wrDataQ [$];
    int rstHigh = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    opl2_cmd_parser #(.FIFO_DEPTH(16), .RST_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_eop(rx_eop), .sample_tick(sample_tick), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .chip_rst(chip_rst), .busy(busy), .overflow(overflow), .err_opcode(err_opcode)
    );

    // Mid-cycle monitor: the handshake seen here is the one taken at the next edge.
    always @(negedge clk) begin
        if (rst_n && wr_valid && wr_ready) begin
            wrAddrQ.push_back(wr_addr);
            wrDataQ.push_back(wr_data);
            $display("[TB] write #%0d addr=0x%02h data=0x%02h", wrAddrQ.size(), wr_addr, wr_data);
        end
        if (chip_rst)   rstHigh++;
        if (err_opcode) errCount++;
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic pulseTick();
        sample_tick = 1'b1;
        tick(1);
        sample_tick = 1'b0;
    endtask

    logic [7:0] ovfBytes [20] = '{8'hA0, 8'h40, 8'h41, 8'hA0, 8'h42, 8'h43, 8'hA0, 8'h44,
                                  8'h45, 8'hA0, 8'h46, 8'h47, 8'hA0, 8'h48, 8'h49, 8'hA2,
                                  8'hE0, 8'hE1, 8'hE2, 8'hE3};

    initial begin
        int base, rBase, eBase;
        rst_n = 1'b0; rx_valid = 1'b0; rx_eop = 1'b0; sample_tick = 1'b0;
        rx_data = 8'h00; wr_ready = 1'b1;
        tick(3);
        checkEq("rst_wr_valid", wr_valid, 0);
        checkEq("rst_chip_rst", chip_rst, 0);
        checkEq("rst_busy", busy, 0);
        checkEq("rst_overflow", overflow, 0);
        checkEq("rst_err", err_opcode, 0);
        checkEq("rst_addr_data", {wr_addr, wr_data}, 16'h0000);
        rst_n = 1'b1;
        tick(1);

        // Single write: wr_valid rises in t+4.
        sendByte(8'hA0); sendByte(8'h08); sendByte(8'h40);
        checkEq("single_t3_valid", wr_valid, 0);
        tick(1);
        checkEq("single_t4_valid", wr_valid, 1);
        checkEq("single_addr", wr_addr, 8'h08);
        checkEq("single_data", wr_data, 8'h40);
        checkEq("single_busy_t4", busy, 1);
        tick(1);
        checkEq("single_t5_valid", wr_valid, 0);
        checkEq("single_busy_t5", busy, 0);
        checkEq("single_count", wrAddrQ.size(), 1);

        // Backpressure: request held with stable addr/data.
        wr_ready = 1'b0;
        sendByte(8'hA0); sendByte(8'h11); sendByte(8'h22);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            checkEq("bp_hold", {wr_valid, wr_addr, wr_data}, {1'b1, 8'h11, 8'h22});
            tick(1);
        end
        checkEq("bp_no_xfer", wrAddrQ.size(), 1);
        wr_ready = 1'b1;
        tick(1);
        checkEq("bp_release_valid", wr_valid, 0);
        checkEq("bp_one_xfer", wrAddrQ.size(), 2);
        checkEq("bp_entry", {wrAddrQ[1], wrDataQ[1]}, 16'h1122);

        // Wait of 3 sample ticks gates the queued write.
        sendByte(8'hA1); sendByte(8'h03); sendByte(8'h00);
        sendByte(8'hA0); sendByte(8'h01); sendByte(8'h20);
        tick(8);
        checkEq("wait_blocked", wr_valid, 0);
        checkEq("wait_busy", busy, 1);
        pulseTick(); pulseTick();
        tick(6);
        checkEq("wait_after2", wr_valid, 0);
        checkEq("wait_after2_cnt", wrAddrQ.size(), 2);
        pulseTick();
        tick(3);
        checkEq("wait_write_valid", wr_valid, 1);
        checkEq("wait_write_ad", {wr_addr, wr_data}, 16'h0120);
        tick(1);
        checkEq("wait_write_cnt", wrAddrQ.size(), 3);

        // Zero-length wait: following write issues with no extra delay.
        sendByte(8'hA1); sendByte(8'h00); sendByte(8'h00);
        sendByte(8'hA0); sendByte(8'h05); sendByte(8'h06);
        tick(1);
        checkEq("wait0_valid", wr_valid, 1);
        checkEq("wait0_ad", {wr_addr, wr_data}, 16'h0506);
        tick(1);
        checkEq("wait0_cnt", wrAddrQ.size(), 4);

        // Chip reset held exactly RST_CYCLES clocks.
        rBase = rstHigh;
        sendByte(8'hA2);
        checkEq("crst_before", chip_rst, 0);
        tick(1);
        checkEq("crst_rise", chip_rst, 1);
        tick(40);
        checkEq("crst_len", rstHigh - rBase, 32);
        checkEq("crst_idle", busy, 0);

        // Unknown opcode: one error pulse, next command still runs.
        eBase = errCount;
        sendByte(8'h5A); sendByte(8'hA0); sendByte(8'h33); sendByte(8'h44);
        tick(4);
        checkEq("badop_pulses", errCount - eBase, 1);
        checkEq("badop_cnt", wrAddrQ.size(), 5);
        checkEq("badop_entry", {wrAddrQ[4], wrDataQ[4]}, 16'h3344);

        // Overflow: 20 bytes pushed while a write is stalled; first 16 kept.
        base = wrAddrQ.size();
        rBase = rstHigh;
        eBase = errCount;
        wr_ready = 1'b0;
        sendByte(8'hA0); sendByte(8'h77); sendByte(8'h88);
        for (int i = 0; i < 20; i++) sendByte(ovfBytes[i]);
        tick(1);
        checkEq("ovf_flag", overflow, 1);
        checkEq("ovf_stalled", wr_valid, 1);
        wr_ready = 1'b1;
        tick(80);
        checkEq("ovf_sticky", overflow, 1);
        checkEq("ovf_cnt", wrAddrQ.size() - base, 6);
        checkEq("ovf_entry0", {wrAddrQ[base], wrDataQ[base]}, 16'h7788);
        for (int k = 0; k < 5; k++) begin
            logic [7:0] a;
            a = 8'h40 + 8'(2 * k);
            checkEq("ovf_order", {wrAddrQ[base + 1 + k], wrDataQ[base + 1 + k]}, {a, a + 8'h01});
        end
        checkEq("ovf_crst", rstHigh - rBase, 32);
        checkEq("ovf_no_err", errCount - eBase, 0);
        checkEq("ovf_drained", busy, 0);

        // Resync on end-of-packet with a partial command.
        base = wrAddrQ.size();
        eBase = errCount;
        sendByte(8'hA0); sendByte(8'h08);
        tick(1);
        rx_eop = 1'b1;
        tick(1);
        rx_eop = 1'b0;
        checkEq("eop_err_pulse", err_opcode, 1);
        checkEq("eop_idle", busy, 0);
        tick(5);
        checkEq("eop_pulses", errCount - eBase, 1);
        checkEq("eop_no_write", wrAddrQ.size(), base);
        rx_eop = 1'b1;
        tick(1);
        rx_eop = 1'b0;
        tick(2);
        checkEq("eop_idle_ignored", errCount - eBase, 1);

        // Reset during a wait with bytes buffered.
        sendByte(8'hA1); sendByte(8'hFF); sendByte(8'h00);
        sendByte(8'hA0); sendByte(8'h01); sendByte(8'h02);
        tick(2);
        checkEq("mid_busy", busy, 1);
        rst_n = 1'b0;
        tick(1);
        checkEq("mid_outputs", {wr_valid, chip_rst, busy, overflow, err_opcode}, 5'b00000);
        checkEq("mid_addr_data", {wr_addr, wr_data}, 16'h0000);
        rst_n = 1'b1;
        tick(10);
        checkEq("mid_fifo_empty", busy, 0);
        checkEq("mid_no_write", wrAddrQ.size(), base);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
